// File: rtl/uart_cfg_if.sv
// uart_cfg_if
//   Byte-level handshake between the system bus glue and the UART core.
//   master : bus glue side (issues tx_start/din, observes status and rx data)
//   slave  : UART core side
//   Signals:
//     tx_start, din                     transmit request and data
//     tx_busy, tx_done_tick             transmitter status
//     rx_done_tick, dout                receive completion and data
//     parity_err, frame_err             status of the last received frame
interface uart_cfg_if #(
  parameter int DBIT = 8
);
  logic            tx_start;
  logic [DBIT-1:0] din;
  logic            tx_busy;
  logic            tx_done_tick;
  logic            rx_done_tick;
  logic [DBIT-1:0] dout;
  logic            parity_err;
  logic            frame_err;

  modport master (
    output tx_start, din,
    input  tx_busy, tx_done_tick, rx_done_tick, dout, parity_err, frame_err
  );

  modport slave (
    input  tx_start, din,
    output tx_busy, tx_done_tick, rx_done_tick, dout, parity_err, frame_err
  );
endinterface

// File: rtl/uart_cfg.sv
// uart_cfg
//   Full-duplex UART with a runtime baud divisor (16x oversampling),
//   configurable data width, optional parity, error flags and loopback.
//   Ports:
//     clk       system clock
//     reset_n   asynchronous reset, active low
//     dvsr      baud divisor: s_tick period = dvsr+1 clk
//     loopback  1 = internal TX stream feeds RX, tx pin held high, rx pin ignored
//     tx        serial output, idle high
//     rx        serial input (asynchronous, synchronised internally)
//     bus       byte handshake (uart_cfg_if.slave)
module uart_cfg #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int DVSR_BIT   = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [DVSR_BIT-1:0] dvsr,
  input  logic                loopback,
  output logic                tx,
  input  logic                rx,
  uart_cfg_if.slave           bus
);

  localparam logic [4:0] TICK_MID  = 5'd7;
  localparam logic [4:0] TICK_LAST = 5'd15;
  localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [3:0] BIT_LAST  = 4'(DBIT - 1);
  localparam logic       PAR_ON    = (PARITY_EN != 0);
  localparam logic       PAR_INV   = (PARITY_ODD != 0);

  // ---------------- baud tick generator ----------------
  logic [DVSR_BIT-1:0] baud_cnt_reg;
  logic                s_tick;

  // ">=" so that lowering dvsr below the running count ticks at once
  assign s_tick = (baud_cnt_reg >= dvsr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    baud_cnt_reg <= '0;
    else if (s_tick) baud_cnt_reg <= '0;
    else             baud_cnt_reg <= baud_cnt_reg + DVSR_BIT'(1);
  end

  // ---------------- rx synchroniser and line select ----------------
  logic [1:0] sync_reg;
  logic       tx_bit_reg;
  logic       rx_line;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_reg <= 2'b11;
    else          sync_reg <= {sync_reg[0], rx};
  end

  assign rx_line = loopback ? tx_bit_reg : sync_reg[1];
  assign tx      = loopback ? 1'b1 : tx_bit_reg;

  // ---------------- transmitter ----------------
  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  tx_state_t       tx_state_reg, tx_state_next;
  logic [4:0]      tx_s_reg, tx_s_next;
  logic [3:0]      tx_n_reg, tx_n_next;
  logic [DBIT-1:0] tx_b_reg, tx_b_next;
  logic            tx_par_reg, tx_par_next;
  logic            tx_bit_next;
  logic            tx_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_reg <= TX_IDLE;
      tx_s_reg     <= '0;
      tx_n_reg     <= '0;
      tx_b_reg     <= '0;
      tx_par_reg   <= 1'b0;
      tx_bit_reg   <= 1'b1;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_s_reg     <= tx_s_next;
      tx_n_reg     <= tx_n_next;
      tx_b_reg     <= tx_b_next;
      tx_par_reg   <= tx_par_next;
      tx_bit_reg   <= tx_bit_next;
    end
  end

  // The serial bit is registered: the next-state logic selects the bit
  // that belongs to the state being entered.
  always_comb begin
    tx_state_next = tx_state_reg;
    tx_s_next     = tx_s_reg;
    tx_n_next     = tx_n_reg;
    tx_b_next     = tx_b_reg;
    tx_par_next   = tx_par_reg;
    tx_bit_next   = tx_bit_reg;
    tx_done       = 1'b0;
    case (tx_state_reg)
      TX_IDLE: begin
        tx_bit_next = 1'b1;
        if (bus.tx_start) begin
          tx_state_next = TX_START;
          tx_s_next     = '0;
          tx_b_next     = bus.din;
          tx_par_next   = (^bus.din) ^ PAR_INV;
          tx_bit_next   = 1'b0;
        end
      end
      TX_START: begin
        if (s_tick) begin
          if (tx_s_reg == TICK_LAST) begin
            tx_state_next = TX_DATA;
            tx_s_next     = '0;
            tx_n_next     = '0;
            tx_bit_next   = tx_b_reg[0];
          end else begin
            tx_s_next = tx_s_reg + 5'd1;
          end
        end
      end
      TX_DATA: begin
        if (s_tick) begin
          if (tx_s_reg == TICK_LAST) begin
            tx_s_next = '0;
            tx_b_next = tx_b_reg >> 1;
            if (tx_n_reg == BIT_LAST) begin
              tx_state_next = PAR_ON ? TX_PARITY : TX_STOP;
              tx_bit_next   = PAR_ON ? tx_par_reg : 1'b1;
            end else begin
              tx_n_next   = tx_n_reg + 4'd1;
              tx_bit_next = tx_b_reg[1];
            end
          end else begin
            tx_s_next = tx_s_reg + 5'd1;
          end
        end
      end
      TX_PARITY: begin
        if (s_tick) begin
          if (tx_s_reg == TICK_LAST) begin
            tx_state_next = TX_STOP;
            tx_s_next     = '0;
            tx_bit_next   = 1'b1;
          end else begin
            tx_s_next = tx_s_reg + 5'd1;
          end
        end
      end
      TX_STOP: begin
        if (s_tick) begin
          if (tx_s_reg == STOP_LAST) begin
            tx_state_next = TX_IDLE;
            tx_done       = 1'b1;
          end else begin
            tx_s_next = tx_s_reg + 5'd1;
          end
        end
      end
      default: begin
        tx_state_next = TX_IDLE;
        tx_bit_next   = 1'b1;
      end
    endcase
  end

  assign bus.tx_busy      = (tx_state_reg != TX_IDLE);
  assign bus.tx_done_tick = tx_done;

  // ---------------- receiver ----------------
  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HI
  } rx_state_t;

  rx_state_t       rx_state_reg, rx_state_next;
  logic [4:0]      rx_s_reg, rx_s_next;
  logic [3:0]      rx_n_reg, rx_n_next;
  logic [DBIT-1:0] rx_b_reg, rx_b_next;
  logic            rx_par_reg, rx_par_next;
  logic [DBIT-1:0] dout_reg, dout_next;
  logic            perr_reg, perr_next;
  logic            ferr_reg, ferr_next;
  logic            rx_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state_reg <= RX_IDLE;
      rx_s_reg     <= '0;
      rx_n_reg     <= '0;
      rx_b_reg     <= '0;
      rx_par_reg   <= 1'b0;
      dout_reg     <= '0;
      perr_reg     <= 1'b0;
      ferr_reg     <= 1'b0;
    end else begin
      rx_state_reg <= rx_state_next;
      rx_s_reg     <= rx_s_next;
      rx_n_reg     <= rx_n_next;
      rx_b_reg     <= rx_b_next;
      rx_par_reg   <= rx_par_next;
      dout_reg     <= dout_next;
      perr_reg     <= perr_next;
      ferr_reg     <= ferr_next;
    end
  end

  always_comb begin
    rx_state_next = rx_state_reg;
    rx_s_next     = rx_s_reg;
    rx_n_next     = rx_n_reg;
    rx_b_next     = rx_b_reg;
    rx_par_next   = rx_par_reg;
    dout_next     = dout_reg;
    perr_next     = perr_reg;
    ferr_next     = ferr_reg;
    rx_done       = 1'b0;
    case (rx_state_reg)
      RX_IDLE: begin
        if (!rx_line) begin
          rx_state_next = RX_START;
          rx_s_next     = '0;
        end
      end
      RX_START: begin
        if (s_tick) begin
          if (rx_s_reg == TICK_MID) begin
            // line back high at mid start bit: treat as a glitch
            if (rx_line) begin
              rx_state_next = RX_IDLE;
            end else begin
              rx_state_next = RX_DATA;
              rx_s_next     = '0;
              rx_n_next     = '0;
            end
          end else begin
            rx_s_next = rx_s_reg + 5'd1;
          end
        end
      end
      RX_DATA: begin
        if (s_tick) begin
          if (rx_s_reg == TICK_LAST) begin
            rx_s_next = '0;
            rx_b_next = {rx_line, rx_b_reg[DBIT-1:1]};
            if (rx_n_reg == BIT_LAST) rx_state_next = PAR_ON ? RX_PARITY : RX_STOP;
            else                      rx_n_next     = rx_n_reg + 4'd1;
          end else begin
            rx_s_next = rx_s_reg + 5'd1;
          end
        end
      end
      RX_PARITY: begin
        if (s_tick) begin
          if (rx_s_reg == TICK_LAST) begin
            rx_s_next     = '0;
            rx_par_next   = rx_line;
            rx_state_next = RX_STOP;
          end else begin
            rx_s_next = rx_s_reg + 5'd1;
          end
        end
      end
      RX_STOP: begin
        if (s_tick) begin
          if (rx_s_reg == STOP_LAST) begin
            rx_done   = 1'b1;
            dout_next = rx_b_reg;
            perr_next = PAR_ON & (((^rx_b_reg) ^ PAR_INV) != rx_par_reg);
            ferr_next = ~rx_line;
            // a low stop bit (framing error or break) must see the line
            // return high before another start can be detected
            rx_state_next = rx_line ? RX_IDLE : RX_WAIT_HI;
          end else begin
            rx_s_next = rx_s_reg + 5'd1;
          end
        end
      end
      RX_WAIT_HI: begin
        if (rx_line) rx_state_next = RX_IDLE;
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  assign bus.rx_done_tick = rx_done;
  assign bus.dout         = dout_reg;
  assign bus.parity_err   = perr_reg;
  assign bus.frame_err    = ferr_reg;

endmodule

// File: tb/tb_uart_cfg.sv
// tb_uart_cfg
//   Self-checking bench for uart_cfg (DBIT=8, even parity enabled, 1 stop bit).
//   Expected frames come from the bench's own data/error choices.
module tb_uart_cfg;
  localparam int DBIT = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] dvsr = 16'd3;
  logic        loopback = 1'b0;
  logic        rx = 1'b1;
  logic        tx;

  uart_cfg_if #(.DBIT(DBIT)) bus ();

  uart_cfg #(
    .DBIT(DBIT), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0), .DVSR_BIT(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .dvsr(dvsr), .loopback(loopback),
    .tx(tx), .rx(rx), .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int rx_cnt = 0;
  int tx_cnt = 0;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } rx_rec_t;
  rx_rec_t rxq[$];

  always @(posedge clk) begin
    if (bus.tx_done_tick === 1'b1) tx_cnt++;
    if (bus.rx_done_tick === 1'b1) begin
      rx_cnt++;
      #1;
      rxq.push_back('{bus.dout, bus.parity_err, bus.frame_err});
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_tx(input logic [7:0] d);
    bus.din = d;
    bus.tx_start = 1'b1;
    cycles(1);
    bus.tx_start = 1'b0;
  endtask

  task automatic wait_tx_done(input int limit, output int n);
    n = 0;
    while (n < limit && bus.tx_done_tick !== 1'b1) begin
      cycles(1);
      n++;
    end
  endtask

  task automatic wait_rx(input string tag, input int target, input int limit);
    int n;
    n = 0;
    while (n < limit && rx_cnt < target) begin
      cycles(1);
      n++;
    end
    chk({tag, "_seen"}, 32'(rx_cnt >= target), 1);
    cycles(1);
  endtask

  task automatic expect_rx(input string tag, input logic [7:0] d, input logic pe, input logic fe);
    rx_rec_t r;
    chk({tag, "_queued"}, 32'(rxq.size() != 0), 1);
    if (rxq.size() != 0) begin
      r = rxq.pop_front();
      chk({tag, "_dout"}, 32'(r.data), 32'(d));
      chk({tag, "_perr"}, 32'(r.perr), 32'(pe));
      chk({tag, "_ferr"}, 32'(r.ferr), 32'(fe));
    end
  endtask

  // 8 data bits, even parity (optionally corrupted), chosen stop bit, then idle
  task automatic drive_frame(input logic [7:0] d, input logic bad_par, input logic stop);
    int bc;
    bc = 16 * (int'(dvsr) + 1);
    rx = 1'b0;
    cycles(bc);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      cycles(bc);
    end
    rx = (^d) ^ bad_par;
    cycles(bc);
    rx = stop;
    cycles(bc);
    rx = 1'b1;
    cycles(2 * bc);
  endtask

  // loopback frame: 11 bits x 16 ticks, done on the 176th tick
  task automatic loop_frame(input string tag, input logic [7:0] d);
    int n, p, base_rx;
    p = int'(dvsr) + 1;
    base_rx = rx_cnt;
    send_tx(d);
    chk({tag, "_busy"}, 32'(bus.tx_busy), 1);
    chk({tag, "_pin_high"}, 32'(tx), 1);
    wait_tx_done(200 * p, n);
    chk({tag, "_len"}, 32'(n >= 175 * p && n < 176 * p + 2), 1);
    wait_rx(tag, base_rx + 1, 64);
    expect_rx(tag, d, 1'b0, 1'b0);
  endtask

  initial begin
    int n, base, tbase, rbase;
    logic [7:0] d;
    logic bp;
    bus.tx_start = 1'b0;
    bus.din = '0;

    // reset values
    cycles(3);
    chk("rst_tx", 32'(tx), 1);
    chk("rst_busy", 32'(bus.tx_busy), 0);
    chk("rst_txdone", 32'(bus.tx_done_tick), 0);
    chk("rst_rxdone", 32'(bus.rx_done_tick), 0);
    chk("rst_dout", 32'(bus.dout), 0);
    chk("rst_flags", 32'({bus.parity_err, bus.frame_err}), 0);
    reset_n = 1'b1;
    cycles(2);

    // 1: asynchronous reset in mid TX frame
    send_tx(8'h5A);
    chk("t1_start_bit", 32'(tx), 0);
    cycles(200);
    chk("t1_midframe_busy", 32'(bus.tx_busy), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t1_async_tx", 32'(tx), 1);
    chk("t1_async_busy", 32'(bus.tx_busy), 0);
    chk("t1_flags", 32'({bus.parity_err, bus.frame_err}), 0);
    cycles(4);
    reset_n = 1'b1;
    cycles(800);
    chk("t1_no_txdone", 32'(tx_cnt), 0);
    chk("t1_no_rxdone", 32'(rx_cnt), 0);
    chk("t1_idle_tx", 32'(tx), 1);

    // 2: loopback, dvsr=3, 0xA5, then random bytes and divisors
    loopback = 1'b1;
    dvsr = 16'd3;
    cycles(2);
    loop_frame("t2_a5", 8'hA5);
    for (int k = 0; k < 5; k++) begin
      dvsr = 16'($urandom_range(0, 3));
      cycles(2);
      d = 8'($urandom_range(0, 255));
      loop_frame($sformatf("t2_rnd%0d", k), d);
    end

    // 3: external rx, wrong parity on 0x3C, then random frames
    loopback = 1'b0;
    dvsr = 16'd1;
    cycles(4);
    base = rx_cnt;
    drive_frame(8'h3C, 1'b1, 1'b1);
    wait_rx("t3_3c", base + 1, 64);
    expect_rx("t3_3c", 8'h3C, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      d = 8'($urandom_range(0, 255));
      bp = 1'($urandom_range(0, 1));
      base = rx_cnt;
      drive_frame(d, bp, 1'b1);
      wait_rx($sformatf("t3_rnd%0d", k), base + 1, 64);
      expect_rx($sformatf("t3_rnd%0d", k), d, bp, 1'b0);
    end

    // 4: break for 3 frame times
    base = rx_cnt;
    rx = 1'b0;
    cycles(3 * 11 * 32);
    chk("t4_one_tick", 32'(rx_cnt - base), 1);
    cycles(1);
    expect_rx("t4_break", 8'h00, 1'b0, 1'b1);
    rx = 1'b1;
    cycles(11 * 32);
    chk("t4_no_more", 32'(rx_cnt - base), 1);
    base = rx_cnt;
    drive_frame(8'h81, 1'b0, 1'b1);
    wait_rx("t4_after", base + 1, 64);
    expect_rx("t4_after", 8'h81, 1'b0, 1'b0);

    // 5: 4-tick glitch on idle line
    base = rx_cnt;
    rx = 1'b0;
    cycles(4 * (int'(dvsr) + 1));
    rx = 1'b1;
    cycles(2 * 11 * 32);
    chk("t5_glitch_none", 32'(rx_cnt - base), 0);
    drive_frame(8'h7E, 1'b0, 1'b1);
    wait_rx("t5_after", base + 1, 64);
    expect_rx("t5_after", 8'h7E, 1'b0, 1'b0);

    // 6: back-to-back frames with a rejected start while busy
    loopback = 1'b1;
    dvsr = 16'd3;
    cycles(4);
    tbase = tx_cnt;
    rbase = rx_cnt;
    send_tx(8'h11);
    cycles(300);
    bus.din = 8'h99;
    bus.tx_start = 1'b1;
    cycles(1);
    bus.tx_start = 1'b0;
    chk("t6_still_busy", 32'(bus.tx_busy), 1);
    wait_tx_done(1000, n);
    chk("t6_done1_seen", 32'(n < 1000), 1);
    cycles(1);
    chk("t6_busy_low", 32'(bus.tx_busy), 0);
    bus.din = 8'h22;
    bus.tx_start = 1'b1;
    cycles(1);
    bus.tx_start = 1'b0;
    chk("t6_accept2", 32'(bus.tx_busy), 1);
    wait_tx_done(1000, n);
    chk("t6_done2_len", 32'(n >= 699 && n < 706), 1);
    cycles(900);
    chk("t6_tx_frames", 32'(tx_cnt - tbase), 2);
    chk("t6_rx_frames", 32'(rx_cnt - rbase), 2);
    expect_rx("t6_f1", 8'h11, 1'b0, 1'b0);
    expect_rx("t6_f2", 8'h22, 1'b0, 1'b0);
    chk("t6_no_extra", 32'(rxq.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
